// File: rtl/ecc_pkg.sv
// ecc_pkg: shared FSM states and default width for the ladder controller.
// Imported by ecc_msb_scan and ecc_ladder_ctrl.
package ecc_pkg;

  localparam int ECC_N = 256;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ADD_REQ,
    ADD_WAIT,
    DBL_REQ,
    DBL_WAIT,
    NEXT,
    DONE
  } state_e;

endpackage

// File: rtl/ecc_msb_scan.sv
// ecc_msb_scan: combinational priority encoder for the scalar.
// Returns the index of the most significant 1 and an all-zero flag.
module ecc_msb_scan
  import ecc_pkg::*;
#(
  parameter  int N  = ECC_N,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          zero_o
);

  // Highest set bit wins: later iterations override earlier ones
  always_comb begin
    idx_o  = '0;
    zero_o = ~|vec_i;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/ecc_ladder_ctrl.sv
// ecc_ladder_ctrl: Montgomery-ladder sequencer for k*P using an external
// point unit. Define ECC_CONST_TIME_EN to always scan from bit N-1.
module ecc_ladder_ctrl
  import ecc_pkg::*;
#(
  parameter int N = ECC_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] Px,
  input  logic [N-1:0] Py,
  input  logic [N-1:0] k,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Rx,
  output logic [N-1:0] Ry,
  output logic         out_inf,
  output logic         op_valid,
  input  logic         op_ready,
  output logic         op_dbl,
  output logic [N-1:0] op_ax,
  output logic [N-1:0] op_ay,
  output logic [N-1:0] op_bx,
  output logic [N-1:0] op_by,
  output logic         op_ainf,
  output logic         op_binf,
  input  logic         res_valid,
  input  logic [N-1:0] res_x,
  input  logic [N-1:0] res_y,
  input  logic         res_inf
);

  localparam int IW = $clog2(N);

  state_e        state_q, state_d;
  logic [N-1:0]  k_q;
  logic [N-1:0]  r0x_q, r0y_q;
  logic [N-1:0]  r1x_q, r1y_q;
  logic          r0i_q, r1i_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] msb_idx;
  logic [IW-1:0] start_idx;
  logic          k_zero;
  logic          bit_b;

  ecc_msb_scan #(
    .N (N)
  ) u_scan (
    .vec_i  (k_q),
    .idx_o  (msb_idx),
    .zero_o (k_zero)
  );

`ifdef ECC_CONST_TIME_EN
  assign start_idx = IW'(N - 1);
`else
  assign start_idx = msb_idx;
`endif

  assign bit_b = k_q[idx_q];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (in_valid)  state_d = SCAN;
      SCAN:     state_d = k_zero ? DONE : ADD_REQ;
      ADD_REQ:  if (op_ready)  state_d = ADD_WAIT;
      ADD_WAIT: if (res_valid) state_d = DBL_REQ;
      DBL_REQ:  if (op_ready)  state_d = DBL_WAIT;
      DBL_WAIT: if (res_valid) state_d = NEXT;
      NEXT:     state_d = (idx_q == '0) ? DONE : ADD_REQ;
      DONE:     if (out_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Job capture, bit index and ladder register updates.
  // The add never writes the register that is doubled next,
  // so DBL_REQ reads the pre-add value straight from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= '0;
      idx_q <= '0;
      r0x_q <= '0;
      r0y_q <= '0;
      r0i_q <= 1'b0;
      r1x_q <= '0;
      r1y_q <= '0;
      r1i_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            k_q   <= k;
            r0x_q <= '0;
            r0y_q <= '0;
            r0i_q <= 1'b1;
            r1x_q <= Px;
            r1y_q <= Py;
            r1i_q <= 1'b0;
          end
        end
        SCAN: idx_q <= start_idx;
        ADD_WAIT: begin
          if (res_valid) begin
            if (bit_b) begin
              r0x_q <= res_x;
              r0y_q <= res_y;
              r0i_q <= res_inf;
            end else begin
              r1x_q <= res_x;
              r1y_q <= res_y;
              r1i_q <= res_inf;
            end
          end
        end
        DBL_WAIT: begin
          if (res_valid) begin
            if (bit_b) begin
              r1x_q <= res_x;
              r1y_q <= res_y;
              r1i_q <= res_inf;
            end else begin
              r0x_q <= res_x;
              r0y_q <= res_y;
              r0i_q <= res_inf;
            end
          end
        end
        NEXT: begin
          if (idx_q != '0) idx_q <= idx_q - IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake and operand outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    Rx        = '0;
    Ry        = '0;
    out_inf   = 1'b0;
    op_valid  = 1'b0;
    op_dbl    = 1'b0;
    op_ax     = '0;
    op_ay     = '0;
    op_ainf   = 1'b0;
    op_bx     = '0;
    op_by     = '0;
    op_binf   = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      ADD_REQ: begin
        op_valid = 1'b1;
        op_ax    = r0x_q;
        op_ay    = r0y_q;
        op_ainf  = r0i_q;
        op_bx    = r1x_q;
        op_by    = r1y_q;
        op_binf  = r1i_q;
      end
      DBL_REQ: begin
        op_valid = 1'b1;
        op_dbl   = 1'b1;
        op_ax    = bit_b ? r1x_q : r0x_q;
        op_ay    = bit_b ? r1y_q : r0y_q;
        op_ainf  = bit_b ? r1i_q : r0i_q;
      end
      DONE: begin
        out_valid = 1'b1;
        Rx        = r0x_q;
        Ry        = r0y_q;
        out_inf   = r0i_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ecc_ladder_ctrl.md
ECC_LADDER_CTRL -- requirements
Module: ecc_ladder_ctrl

Interface
REQ-001 Parameter: N, 256, operand/scalar width in bits (legal 8..521).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid / in_ready  input / output  1 / 1  job handshake; job accepted on cycle both high.
REQ-005 Px, Py, k  input  N each  base point affine coordinates, scalar.
REQ-006 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-007 Rx, Ry  output  N each  result k*P coordinates.
REQ-008 out_inf  output  1  result is point at infinity.
REQ-009 op_valid / op_ready  output / input  1 / 1  request to external point-arithmetic unit.
REQ-010 op_dbl  output  1  1 = double operand A, 0 = add A+B.
REQ-011 op_ax, op_ay, op_bx, op_by  output  N each; op_ainf, op_binf  output  1 each  operands and infinity flags.
REQ-012 res_valid  input  1; res_x, res_y  input  N; res_inf  input  1  arithmetic result, one pulse per request.

Function
REQ-013 Block SHALL compute k*P by Montgomery ladder: R0 = O, R1 = P; per bit b from scan start down to 0: b=1 -> R0=R0+R1, R1=2*R1; b=0 -> R1=R0+R1, R0=2*R0; result = R0.
REQ-014 FSM states SHALL be IDLE, SCAN, ADD_REQ, ADD_WAIT, DBL_REQ, DBL_WAIT, NEXT, DONE.
REQ-015 IDLE: in_ready=1; on accept latch Px, Py, k; go SCAN.
REQ-016 SCAN: one cycle; set bit index to start position (REQ-029/030); k=0 -> DONE with out_inf=1.
REQ-017 ADD_REQ: op_valid=1, op_dbl=0, A=R0, B=R1; stay until op_ready; then ADD_WAIT.
REQ-018 ADD_WAIT: on res_valid store result into R0 (b=1) or R1 (b=0); go DBL_REQ.
REQ-019 DBL_REQ/DBL_WAIT: same handshake, op_dbl=1, A=R1 (b=1) or R0 (b=0); result stored into the doubled register.
REQ-020 Doubling SHALL use the pre-add value of its register (snapshot at ADD_REQ).
REQ-021 NEXT: index=0 -> DONE, else decrement index, go ADD_REQ.
REQ-022 DONE: out_valid=1, Rx/Ry/out_inf = R0 held stable until out_ready; then IDLE.
REQ-023 op_valid SHALL not drop before op_ready; operands stable while op_valid=1.
REQ-024 res_valid outside ADD_WAIT/DBL_WAIT SHALL be ignored.
REQ-025 in_valid while busy SHALL be ignored (in_ready=0); no queueing.
REQ-026 out_ready=1 with out_valid=0 SHALL have no effect.
REQ-027 Same-cycle out_ready accept and in_valid: in_ready=0 that cycle; new job accepted next cycle at earliest.

Reset
REQ-028 On rst_n low, at any state including mid-job: state=IDLE, in_ready=1, out_valid=0, op_valid=0, Rx=Ry=0, out_inf=0, R0/R1 cleared; in-flight res_valid after reset ignored.

Configuration
REQ-029 Macro ECC_CONST_TIME_EN defined: scan start always N-1, leading zeros processed; exactly 2N ops per nonzero-k job independent of k.
REQ-030 Macro undefined: scan start = index of most significant 1 of k; op count = 2*(msb+1).

Structure
REQ-031 Shared package ecc_pkg: state enum, default width constant ECC_N=256.
REQ-032 Sub-module ecc_msb_scan: combinational priority encoder, N-bit in, index and zero flag out.

Verification
REQ-033 k=1, P=(Gx,Gy), unit 1-cycle latency -> out_valid with Rx=Gx, Ry=Gy, out_inf=0; ops=2 (undefined) or 512 (defined).
REQ-034 k=0 -> out_valid two cycles after accept, out_inf=1, zero ops issued.
REQ-035 k=7, reference software model for unit -> R = 7G; op sequence add,dbl x3 in exact order with correct A/B/inf flags.
REQ-036 op_ready held low 5 cycles per request -> op_valid and operands stable, result unchanged.
REQ-037 rst_n pulsed in DBL_WAIT at k=0xFF -> IDLE next cycle, out_valid=0, following job k=2 correct (2G).
REQ-038 out_ready low 10 cycles in DONE, in_valid high throughout -> outputs stable, in_ready=0, no second accept.
